// File: rtl/serial_sub_ctrl_if.sv
// rtl/serial_sub_ctrl_if.sv - request/result bundle for the bit-serial subtractor
// Optional ovf signal present when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b,
        input  busy, done, diff, bout
`ifdef SERIAL_SUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bout
`ifdef SERIAL_SUB_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial A-B using one full-subtractor cell, LSB first
// SERIAL_SUB_OVF_EN adds a registered signed-overflow flag alongside bout.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    serial_sub_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             bout_q;
    logic             busy_q;
    logic             done_q;
    logic             d_bit;
    logic             b_bit;
    logic             last_bit;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q;
`endif

    always_comb begin
        d_bit    = sh_a[0] ^ sh_b[0] ^ brw;
        b_bit    = (~sh_a[0] & sh_b[0]) | (~(sh_a[0] ^ sh_b[0]) & brw);
        last_bit = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sh_a   <= '0;
            sh_b   <= '0;
            res    <= '0;
            diff_q <= '0;
            cnt    <= '0;
            brw    <= 1'b0;
            bout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            case (state)
                // DONE accepts a new request exactly like IDLE so throughput is WIDTH+1
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        sh_a   <= bus.a;
                        sh_b   <= bus.b;
                        brw    <= 1'b0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    sh_a <= sh_a >> 1;
                    sh_b <= sh_b >> 1;
                    res  <= {d_bit, res[WIDTH-1:1]};
                    brw  <= b_bit;
                    cnt  <= cnt + 1'b1;
                    if (last_bit) begin
                        diff_q <= {d_bit, res[WIDTH-1:1]};
                        bout_q <= b_bit;
`ifdef SERIAL_SUB_OVF_EN
                        // On the last step the shift LSBs hold the original operand MSBs
                        ovf_q  <= (sh_a[0] ^ sh_b[0]) & (d_bit ^ sh_a[0]);
`endif
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf  = ovf_q;
`endif
endmodule
